traffic_intersection_ctrl: RTL

Two-road (NS/EW) intersection controller. It is the parametrised successor to the single-light traffic controller. Adds:
- per-phase programmable durations and counter width
- all-red clearance phases
- latched pedestrian walk phase
- EW vehicle-sensor rest-in-NS-green
- emergency all-red preemption

Exports safety property bits (expected constant 0) for formal checking in the verification flow.

---
 rtl/traffic_intersection_ctrl_pkg.sv | 53 +++++
 rtl/traffic_intersection_ctrl_phase_timer.sv | 26 ++
 rtl/traffic_intersection_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/traffic_intersection_ctrl_pkg.sv
// Shared types for the two-road intersection controller: light codes, phase
// states and the per-phase load value.
package traffic_pkg;

    localparam logic [1:0] RED    = 2'd0;
    localparam logic [1:0] GREEN  = 2'd1;
    localparam logic [1:0] YELLOW = 2'd2;

    typedef enum logic [2:0] {
        AR_NS,
        NS_G,
        NS_Y,
        AR_EW,
        EW_G,
        EW_Y,
        PED,
        EHOLD
    } state_t;

    // Counter load value for a phase (duration minus one); EHOLD parks at zero.
    function automatic int unsigned duration(input state_t s,
                                             input int unsigned g_ns,
                                             input int unsigned g_ew,
                                             input int unsigned yel,
                                             input int unsigned ar,
                                             input int unsigned pw);
        case (s)
            AR_NS, AR_EW: return ar - 1;
            NS_G:         return g_ns - 1;
            EW_G:         return g_ew - 1;
            NS_Y, EW_Y:   return yel - 1;
            PED:          return pw - 1;
            default:      return 0;
        endcase
    endfunction

    function automatic logic [1:0] ns_light(input state_t s);
        case (s)
            NS_G:    return GREEN;
            NS_Y:    return YELLOW;
            default: return RED;
        endcase
    endfunction

    function automatic logic [1:0] ew_light(input state_t s);
        case (s)
            EW_G:    return GREEN;
            EW_Y:    return YELLOW;
            default: return RED;
        endcase
    endfunction

endpackage

// File: rtl/traffic_intersection_ctrl_phase_timer.sv
// Loadable down-counter that times each phase; stops at zero until reloaded.
module phase_timer #(
    parameter int          CNT_W   = 8,
    parameter int unsigned RST_VAL = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= CNT_W'(RST_VAL);
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// Two-road intersection controller with all-red clearance, latched pedestrian
// walk, EW sensor rest-in-NS-green and emergency all-red preemption.
//
// state | meaning
// AR_NS | all-red clearance before NS green
// NS_G  | NS green (rests here while no EW demand)
// NS_Y  | NS yellow
// AR_EW | all-red clearance before EW green
// EW_G  | EW green
// EW_Y  | EW yellow
// PED   | pedestrian walk, both roads red
// EHOLD | emergency hold, both red until emerg drops
module traffic_intersection_ctrl
    import traffic_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int GREEN_NS = 40,
    parameter int GREEN_EW = 30,
    parameter int YELLOW   = 5,
    parameter int ALL_RED  = 2,
    parameter int PED_WALK = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             emerg,
    input  logic             ped_req,
    input  logic             ew_sense,
    output logic [1:0]       light_ns,
    output logic [1:0]       light_ew,
    output logic             walk,
    output logic [CNT_W-1:0] time_left,
    output logic             p_conflict,
    output logic             p_walk_bad,
    output logic             p_overrun
);

    state_t           state, state_nxt;
    logic             ped_pending;
    logic             ret_ew;
    logic             ped_enter;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] count;
    logic             cnt_zero;

    function automatic int unsigned dur(input state_t s);
        return duration(s, GREEN_NS, GREEN_EW, YELLOW, ALL_RED, PED_WALK);
    endfunction

    phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (ALL_RED - 1)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_nxt = state;
        ped_enter = 1'b0;
        case (state)
            AR_NS, AR_EW: begin
                if (cnt_zero) begin
                    if (emerg)            state_nxt = EHOLD;
                    else if (ped_pending) state_nxt = PED;
                    else                  state_nxt = (state == AR_NS) ? NS_G : EW_G;
                end
            end
            NS_G: begin
                if (emerg) state_nxt = NS_Y;
                else if (cnt_zero && (ew_sense || ped_pending)) state_nxt = NS_Y;
            end
            NS_Y:  if (cnt_zero) state_nxt = AR_EW;
            EW_G:  if (emerg || cnt_zero) state_nxt = EW_Y;
            EW_Y:  if (cnt_zero) state_nxt = AR_NS;
            PED: begin
                if (emerg)         state_nxt = EHOLD;
                else if (cnt_zero) state_nxt = ret_ew ? EW_G : NS_G;
            end
            EHOLD: if (!emerg) state_nxt = AR_NS;
            default: state_nxt = AR_NS;
        endcase

        // A phase reloads on any state change, and NS_G also reloads when it rests.
        load = (state_nxt != state) || (state == NS_G && cnt_zero);
        load_val = CNT_W'(dur(state_nxt));
        ped_enter = (state_nxt == PED) && (state != PED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= AR_NS;
            ped_pending <= 1'b0;
            ret_ew      <= 1'b0;
            light_ns    <= RED;
            light_ew    <= RED;
            walk        <= 1'b0;
        end else begin
            state    <= state_nxt;
            light_ns <= ns_light(state_nxt);
            light_ew <= ew_light(state_nxt);
            walk     <= (state_nxt == PED);
            if (ped_enter) begin
                ped_pending <= 1'b0;
                ret_ew      <= (state == AR_EW);
            end else if (ped_req && state != PED) begin
                ped_pending <= 1'b1;
            end
        end
    end

    assign time_left  = count;
    assign p_conflict = (ns_light(state) != RED) && (ew_light(state) != RED);
    assign p_walk_bad = (state == PED) &&
                        ((ns_light(state) != RED) || (ew_light(state) != RED));
    assign p_overrun  = (32'(count) > dur(state));

endmodule
